// File: rtl/rssb_pkg.sv
// Shared types and constants for the RSSB one-instruction controller.
package rssb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } rssb_state_e;

  // An operand fetch returning this value stops the machine.
  localparam logic [7:0] HALT_ADDR_DEFAULT = 8'hFF;

endpackage

// File: rtl/rssb_alu.sv
// Subtract-with-borrow datapath: diff = rdata - acc, borrow when rdata < acc.
module rssb_alu #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] rdata,
  input  logic [WIDTH-1:0] acc,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  // Modular difference plus unsigned borrow flag.
  always_comb begin
    diff   = rdata - acc;
    borrow = (rdata < acc);
  end

endmodule

// File: rtl/rssb_ctrl.sv
// RSSB controller: fetch operand address, subtract, write back, skip on borrow.
// Defining RSSB_INSTR_COUNT_EN adds the instr_cnt retired-instruction counter.
module rssb_ctrl
  import rssb_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] HALT_ADDR = HALT_ADDR_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic [WIDTH-1:0] mem_addr,
  output logic             mem_write,
  output logic [WIDTH-1:0] mem_wdata,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] acc,
  output logic             halted
`ifdef RSSB_INSTR_COUNT_EN
  ,
  output logic [WIDTH-1:0] instr_cnt
`endif
);

  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  rssb_state_e      state_r;
  rssb_state_e      next_state_s;
  logic [WIDTH-1:0] pc_r;
  logic [WIDTH-1:0] acc_r;
  logic [WIDTH-1:0] opr_r;
  logic [WIDTH-1:0] diff_s;
  logic             borrow_s;
  logic [WIDTH-1:0] pc_step_s;

  rssb_alu #(.WIDTH(WIDTH)) u_alu (
    .rdata  (mem_rdata),
    .acc    (acc_r),
    .diff   (diff_s),
    .borrow (borrow_s)
  );

  // Borrow skips the next instruction: step is 2 on borrow, otherwise 1.
  assign pc_step_s = {{(WIDTH-2){1'b0}}, borrow_s, ~borrow_s};

  assign pc  = pc_r;
  assign acc = acc_r;

  // Next-state and RAM-port decode; outputs follow the registered state only.
  always_comb begin
    next_state_s = state_r;
    mem_addr     = pc_r;
    mem_write    = 1'b0;
    mem_wdata    = ZERO;
    halted       = 1'b0;
    case (state_r)
      IDLE: begin
        if (run) next_state_s = FETCH;
        else     next_state_s = IDLE;
      end
      FETCH: begin
        if (mem_rdata == HALT_ADDR) next_state_s = HALT;
        else                        next_state_s = EXEC;
      end
      EXEC: begin
        mem_addr  = opr_r;
        mem_write = 1'b1;
        mem_wdata = diff_s;
        if (run) next_state_s = FETCH;
        else     next_state_s = IDLE;
      end
      HALT: begin
        halted       = 1'b1;
        next_state_s = HALT;
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // State, operand latch and architectural pc/acc; reset aborts any write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      pc_r    <= ZERO;
      acc_r   <= ZERO;
      opr_r   <= ZERO;
    end else begin
      state_r <= next_state_s;
      if (state_r == FETCH) begin
        opr_r <= mem_rdata;
      end
      if (state_r == EXEC) begin
        acc_r <= diff_s;
        pc_r  <= pc_r + pc_step_s;
      end
    end
  end

`ifdef RSSB_INSTR_COUNT_EN
  logic [WIDTH-1:0] instr_cnt_r;

  // Retired-instruction count; only an EXEC edge advances it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr_cnt_r <= ZERO;
    end else if (state_r == EXEC) begin
      instr_cnt_r <= instr_cnt_r + ONE;
    end
  end

  assign instr_cnt = instr_cnt_r;
`endif

endmodule

// File: doc/rssb_ctrl.md
RSSB_CTRL -- requirements
Module: rssb_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data/address width.
REQ-002 SHALL have parameter HALT_ADDR, default all-ones (8'hFF): fetched operand value that stops execution.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port run, input, 1: level enable; high starts or continues execution.
REQ-006 SHALL have port mem_rdata, input, WIDTH: combinational read data from the RAM at mem_addr.
REQ-007 SHALL have port mem_addr, output, WIDTH: RAM address.
REQ-008 SHALL have port mem_write, output, 1: RAM write enable, sampled by the RAM at the rising edge.
REQ-009 SHALL have port mem_wdata, output, WIDTH: RAM write data.
REQ-010 SHALL have port pc, output, WIDTH: program counter.
REQ-011 SHALL have port acc, output, WIDTH: accumulator.
REQ-012 SHALL have port halted, output, 1: high in HALT state.

Function
REQ-013 SHALL implement FSM states IDLE, FETCH, EXEC, HALT.
REQ-014 IDLE: mem_write=0; run=1 -> FETCH next cycle; else stay.
REQ-015 FETCH: mem_addr=pc, mem_write=0; opr <= mem_rdata; if mem_rdata==HALT_ADDR -> HALT, pc/acc unchanged; else -> EXEC.
REQ-016 EXEC: mem_addr=opr, mem_write=1, mem_wdata=diff where diff = mem_rdata - acc modulo 2^WIDTH.
REQ-017 EXEC edge: acc <= diff; borrow = (mem_rdata < acc) unsigned; pc <= pc+2 if borrow else pc+1, modulo 2^WIDTH.
REQ-018 EXEC next state: FETCH if run=1, else IDLE; an instruction in EXEC always completes regardless of run.
REQ-019 Latency: exactly 2 cycles per non-halt instruction, one RAM write per instruction.
REQ-020 PC wrap: pc=FF with no borrow -> 00; pc=FF with borrow -> 01; pc=FE with borrow -> 00.
REQ-021 HALT: sticky until reset; ignores run; mem_write=0; halted=1.
REQ-022 mem_addr SHALL equal pc in IDLE and HALT; mem_wdata SHALL be 0 outside EXEC.
REQ-023 Operand equal to acc: diff=0, borrow=0, pc+1.

Reset
REQ-024 rst low SHALL immediately force state=IDLE, pc=0, acc=0, opr=0, mem_write=0, halted=0, independent of clk.
REQ-025 rst asserted during EXEC SHALL abort the write: mem_write drops with rst, and no pc/acc update occurs.
REQ-026 After rst deassertion, first FETCH SHALL occur one cycle after run is sampled high.

Configuration
REQ-027 Macro RSSB_INSTR_COUNT_EN defined: extra output instr_cnt, WIDTH bits, reset 0, increments at each EXEC edge, wraps modulo 2^WIDTH, holds in HALT.
REQ-028 Macro RSSB_INSTR_COUNT_EN undefined: no instr_cnt port and no counter logic; all other behaviour identical.

Structure
REQ-029 Package rssb_pkg SHALL hold the state enum typedef (IDLE, FETCH, EXEC, HALT) and the default HALT_ADDR constant.
REQ-030 Sub-module rssb_alu SHALL compute diff and borrow combinationally from (mem_rdata, acc); no other sub-modules.

Verification
REQ-031 Reset: rst low mid-EXEC with run=1 -> pc=0, acc=0, mem_write=0 in the same cycle; state IDLE.
REQ-032 No borrow: acc=0, pc=0, mem[0]=0x80, mem[0x80]=0x01 -> after 2 cycles mem[0x80]=0x01, acc=0x01, pc=1.
REQ-033 Borrow skip: acc=0x05, mem[pc=3]=0x82, mem[0x82]=0x02 -> mem[0x82]=0xFD, acc=0xFD, pc=5.
REQ-034 Halt: mem[pc]=0xFF -> halted=1 after FETCH, no RAM write, pc/acc held; run toggling has no effect.
REQ-035 Pause: run dropped during EXEC -> instruction completes, state IDLE, no further writes; run=1 resumes at the next pc.
REQ-036 Wrap and counter: pc=0xFF with borrow -> pc=0x01; with RSSB_INSTR_COUNT_EN, 256 instructions -> instr_cnt=0x00.
